// File: rtl/regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler
//
// Drives the register file's single write port from two writeback sources:
//   - the single-cycle ALU result, which always wins the slot when it targets
//     a real register;
//   - load returns from the data cache, which are buffered in a small circular
//     FIFO and drain whenever the ALU leaves the slot free.
// It also keeps a per-register busy scoreboard so decode can stall on
// registers that still have a load in flight.
//
// Ports
//   clk, rst                 clock (posedge) / asynchronous active-low reset
//   alu_we/alu_rd/alu_data   ALU writeback, no backpressure
//   ld_issue/ld_issue_rd     load issued to the cache (sets busy bit)
//   ld_valid/ld_rd/ld_data   load return from the cache
//   ld_ready                 FIFO can accept a load return (0 during reset)
//   writeRpoint/writeData/
//   writeEnable              registered register-file write port
//   busy_mask                bit i = load pending to register i
//   q_count                  FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_write_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_we,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      ld_issue,
    input  logic [ADDR_W-1:0]         ld_issue_rd,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_rd,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    output logic [ADDR_W-1:0]         writeRpoint,
    output logic [DATA_W-1:0]         writeData,
    output logic                      writeEnable,
    output logic [(2**ADDR_W)-1:0]    busy_mask,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**ADDR_W;

    // FIFO storage and pointers. QDEPTH is a power of two, so the pointers
    // wrap naturally at their width.
    logic [ADDR_W-1:0] q_rd   [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic              alu_go;
    logic              push;
    logic              pop;
    logic              emit;
    logic [ADDR_W-1:0] emit_rd;
    logic [DATA_W-1:0] emit_data;
    logic [NREG-1:0]   busy_nxt;

    // Readiness depends only on the registered count: a full queue refuses a
    // return even when it is draining this cycle, which keeps the path short.
    assign ld_ready = rst && (q_count < CW'(QDEPTH));

    // A write to register 0 is no write at all, so it leaves the slot free.
    assign alu_go = alu_we && (alu_rd != '0);
    // Returns to register 0 complete the handshake but are dropped here.
    assign push   = ld_valid && ld_ready && (ld_rd != '0);
    assign pop    = !alu_go && (q_count != '0);
    assign emit   = alu_go || pop;

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        emit_rd   = q_rd[head];
        emit_data = q_data[head];
        if (alu_go) begin
            emit_rd   = alu_rd;
            emit_data = alu_data;
        end
    end

    // Scoreboard next state: clear on emit first, then set, so a new issue to
    // the same register on the same edge keeps the bit busy.
    always_comb begin
        busy_nxt = busy_mask;
        if (pop) begin
            busy_nxt[q_rd[head]] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            q_count     <= '0;
            busy_mask   <= '0;
            writeEnable <= 1'b0;
            writeRpoint <= '0;
            writeData   <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                q_count <= q_count + 1'b1;
            end else if (pop && !push) begin
                q_count <= q_count - 1'b1;
            end

            busy_mask   <= busy_nxt;
            writeEnable <= emit;
            // Index and data hold their last values when the slot is idle.
            if (emit) begin
                writeRpoint <= emit_rd;
                writeData   <= emit_data;
            end
        end
    end

    // NOTE: the FIFO array is deliberately not reset; the pointers and count
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= ld_rd;
            q_data[tail] <= ld_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_scheduler
//
// Self-checking bench for regfile_write_scheduler: a table of per-cycle
// vectors with expected outputs, followed by hand-written sequences for
// queue fill/wrap and mid-stream reset. Expected writes go into scoreboard
// queues when stimulus is driven and are popped when the DUT writes.
// ---------------------------------------------------------------------------
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  writeRpoint;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] busy_mask;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5), .QDEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_we      (alu_we),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .writeRpoint (writeRpoint),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .busy_mask   (busy_mask),
        .q_count     (q_count)
    );

    // Register file model: captures the write port on the falling edge.
    logic [31:0] rf [32];
    always @(negedge clk) begin
        if (writeEnable) rf[writeRpoint] <= writeData;
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        alu_we;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        iss;
        logic [4:0]  iss_rd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic [2:0]  exp_q;
        logic        exp_rdy;
        logic [31:0] exp_busy;
    } vec_t;

    wr_t  sb  [$];   // expected writes whose source is known at drive time
    wr_t  lsb [$];   // accepted load returns, in arrival order
    vec_t vecs [14];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic aw, input logic [4:0] ar, input logic [31:0] ad,
        input logic iss, input logic [4:0] ir,
        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
        input logic ewe, input logic [4:0] erd, input logic [31:0] edat,
        input logic [2:0] eq, input logic erdy, input logic [31:0] ebusy);
        vec_t v;
        v.alu_we = aw;   v.alu_rd = ar;   v.alu_data = ad;
        v.iss = iss;     v.iss_rd = ir;
        v.lv = lv;       v.lrd = lr;      v.ldata = ld;
        v.exp_we = ewe;  v.exp_rd = erd;  v.exp_data = edat;
        v.exp_q = eq;    v.exp_rdy = erdy; v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                         input logic iss, input logic [4:0] ir,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_we = aw;  alu_rd = ar;  alu_data = ad;
        ld_issue = iss;  ld_issue_rd = ir;
        ld_valid = lv;   ld_rd = lr;  ld_data = ld;
    endtask

    // Advance one edge and check the write port. src: 0 = no write expected,
    // 1 = next entry of sb, 2 = next entry of lsb.
    task automatic tick(input int src);
        wr_t e;
        @(posedge clk);
        #1;
        check("write_enable", 32'(writeEnable), 32'(src != 0));
        if (writeEnable && src != 0) begin
            if ((src == 1 && sb.size() == 0) || (src == 2 && lsb.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got a write to r%0d with no expected entry", writeRpoint);
            end else begin
                e = (src == 1) ? sb.pop_front() : lsb.pop_front();
                check("write_rd", 32'(writeRpoint), 32'(e.rd));
                check("write_data", writeData, e.data);
            end
        end
    endtask

    initial begin
        // Vectors: ALU only, priority over queued load, zero register, scoreboard race.
        vecs[0]  = mk(1, 5'd5, 32'h1234, 0, 5'd0, 0, 5'd0,  32'h0,  1, 5'd5,  32'h1234, 3'd0, 1, 32'h0);
        vecs[1]  = mk(0, 5'd0, 32'h0,    1, 5'd7, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,    3'd0, 1, 32'h80);
        vecs[2]  = mk(1, 5'd3, 32'h33,   0, 5'd0, 1, 5'd7,  32'hAA, 1, 5'd3,  32'h33,   3'd1, 1, 32'h80);
        vecs[3]  = mk(1, 5'd3, 32'h34,   0, 5'd0, 0, 5'd0,  32'h0,  1, 5'd3,  32'h34,   3'd1, 1, 32'h80);
        vecs[4]  = mk(0, 5'd0, 32'h0,    1, 5'd10,0, 5'd0,  32'h0,  1, 5'd7,  32'hAA,   3'd0, 1, 32'h400);
        vecs[5]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 1, 5'd10, 32'h10, 0, 5'd0,  32'h0,    3'd1, 1, 32'h400);
        vecs[6]  = mk(1, 5'd0, 32'hDEAD, 0, 5'd0, 0, 5'd0,  32'h0,  1, 5'd10, 32'h10,   3'd0, 1, 32'h0);
        vecs[7]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 1, 5'd0,  32'h55, 0, 5'd0,  32'h0,    3'd0, 1, 32'h0);
        vecs[8]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,    3'd0, 1, 32'h0);
        vecs[9]  = mk(0, 5'd0, 32'h0,    1, 5'd9, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,    3'd0, 1, 32'h200);
        vecs[10] = mk(1, 5'd2, 32'h22,   0, 5'd0, 1, 5'd9,  32'h99, 1, 5'd2,  32'h22,   3'd1, 1, 32'h200);
        vecs[11] = mk(0, 5'd0, 32'h0,    1, 5'd9, 0, 5'd0,  32'h0,  1, 5'd9,  32'h99,   3'd0, 1, 32'h200);
        vecs[12] = mk(0, 5'd0, 32'h0,    0, 5'd0, 1, 5'd9,  32'h98, 0, 5'd0,  32'h0,    3'd1, 1, 32'h200);
        vecs[13] = mk(0, 5'd0, 32'h0,    0, 5'd0, 0, 5'd0,  32'h0,  1, 5'd9,  32'h98,   3'd0, 1, 32'h0);

        // Power-on reset.
        rst = 1'b0;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        #1;
        check("rst_we", 32'(writeEnable), 32'h0);
        check("rst_q", 32'(q_count), 32'h0);
        check("rst_busy", busy_mask, 32'h0);
        check("rst_ready", 32'(ld_ready), 32'h0);
        check("rst_rpoint", 32'(writeRpoint), 32'h0);
        check("rst_data", writeData, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("ready_after_rst", 32'(ld_ready), 32'h1);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].alu_we, vecs[i].alu_rd, vecs[i].alu_data,
                  vecs[i].iss, vecs[i].iss_rd,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
            if (vecs[i].exp_we) sb.push_back('{vecs[i].exp_rd, vecs[i].exp_data});
            tick(vecs[i].exp_we ? 1 : 0);
            check($sformatf("v%0d_q", i), 32'(q_count), 32'(vecs[i].exp_q));
            check($sformatf("v%0d_ready", i), 32'(ld_ready), 32'(vecs[i].exp_rdy));
            check($sformatf("v%0d_busy", i), busy_mask, vecs[i].exp_busy);
        end

        // Idle slot: index/data hold the last write; register 5 kept its value.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        tick(0);
        check("hold_rpoint", 32'(writeRpoint), 32'd9);
        check("hold_data", writeData, 32'h98);
        check("rf_r5", rf[5], 32'h1234);

        // Fill: ALU writes every cycle while loads rd1..rd4 queue up.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(20 + i), 32'(32'hA0 + i), 0, 5'd0, 1, 5'(i), 32'(32'h100 + i));
            sb.push_back('{5'(20 + i), 32'(32'hA0 + i)});
            lsb.push_back('{5'(i), 32'(32'h100 + i)});
            tick(1);
            check("fill_q", 32'(q_count), 32'(i));
            check("fill_ready", 32'(ld_ready), 32'(i < 4));
        end
        // Full: rd5 is presented but refused.
        drive(1, 5'd25, 32'hA5, 0, 5'd0, 1, 5'd5, 32'h105);
        sb.push_back('{5'd25, 32'hA5});
        tick(1);
        check("full_q", 32'(q_count), 32'd4);
        check("full_ready", 32'(ld_ready), 32'h0);
        // ALU idles: pop happens but the held rd5 is still refused this edge.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd5, 32'h105);
        tick(2);
        check("drain_first_q", 32'(q_count), 32'd3);
        // rd5..rd8 arrive as space frees; push and pop on the same edge, pointers wrap.
        for (int j = 5; j <= 8; j++) begin
            drive(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'(j), 32'(32'h100 + j));
            lsb.push_back('{5'(j), 32'(32'h100 + j)});
            tick(2);
            check("pushpop_q", 32'(q_count), 32'd3);
        end
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        for (int k = 2; k >= 0; k--) begin
            tick(2);
            check("drain_q", 32'(q_count), 32'(k));
        end
        check("order_left", 32'(lsb.size()), 32'h0);

        // Mid-stream reset with three loads queued behind ALU traffic.
        drive(0, 5'd0, 32'h0, 1, 5'd11, 0, 5'd0, 32'h0);
        tick(0);
        check("pre_rst_busy", busy_mask, 32'h800);
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd12, 32'(32'hC0 + k), 0, 5'd0, 1, 5'(11 + k), 32'(32'hD0 + k));
            sb.push_back('{5'd12, 32'(32'hC0 + k)});
            lsb.push_back('{5'(11 + k), 32'(32'hD0 + k)});
            tick(1);
        end
        check("pre_rst_q", 32'(q_count), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(writeEnable), 32'h0);
        check("mid_rst_q", 32'(q_count), 32'h0);
        check("mid_rst_busy", busy_mask, 32'h0);
        check("mid_rst_ready", 32'(ld_ready), 32'h0);
        lsb.delete();
        @(posedge clk);
        #1;
        check("held_rst_ready", 32'(ld_ready), 32'h0);
        check("held_rst_we", 32'(writeEnable), 32'h0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        #1 check("rel_rst_ready", 32'(ld_ready), 32'h1);
        tick(0);
        check("post_rst_q", 32'(q_count), 32'h0);

        check("sb_left", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
